multi_entry_eviction_buffer: RTL and testbench
==============================================

MULTI_ENTRY_EVICTION_BUFFER -- requirements
Module: multi_entry_eviction_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered victim lines (power of 2, >=2).
REQ-002 SHALL have parameter LINE_WIDTH, default 256, bits per cache line.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-004 SHALL have parameter OFFSET_BITS, default 5, line-offset bits ignored in address compares.
REQ-005 One clock; reset is asynchronous and active-high: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-006 SHALL have ports: evict_valid  in  1  L2 pushes a victim line; evict_address  in  ADDR_WIDTH  victim address; evict_data  in  LINE_WIDTH  victim data; evict_ready  out  1  buffer accepts a push.
REQ-007 SHALL have ports: l2_address  in  ADDR_WIDTH  L2 lookup address; hit  out  1  lookup matches a valid entry; hit_data  out  LINE_WIDTH  data of matching entry.
REQ-008 SHALL have ports: l2pmem_read  in  1  L2 owns pmem for a read; l2pmem_write  in  1  L2 owns pmem for a write.
REQ-009 SHALL have ports: pmem_write  out  1  buffer write to pmem; pmem_address  out  ADDR_WIDTH  write address; pmem_wdata  out  LINE_WIDTH  write data; pmem_resp  in  1  pmem completion.
REQ-010 SHALL have ports: flush  in  1  one-cycle drain-all request; flush_done  out  1  one-cycle pulse when flush complete; blocking  out  1  buffer owns pmem; count  out  $clog2(DEPTH)+1  valid entries.

Function
REQ-011 Storage SHALL be a circular FIFO of DEPTH entries {valid, line address [ADDR_WIDTH-1:OFFSET_BITS], data}; head/tail pointers wrap modulo DEPTH.
REQ-012 evict_ready SHALL equal (count < DEPTH); a push with evict_ready low SHALL be ignored; a pop in the same cycle SHALL NOT raise evict_ready combinationally.
REQ-013 Push whose line address matches a valid non-head-in-flight entry SHALL overwrite that entry's data in place (coalesce); count unchanged; coalesce SHALL be accepted even when full.
REQ-014 Push matching only the head while the FSM is in WRITE SHALL allocate a new tail entry (in-flight data never modified).
REQ-015 hit/hit_data SHALL be combinational from l2_address; on multiple matches the youngest entry SHALL win; a same-cycle push SHALL NOT be visible until the next cycle.
REQ-016 Drain FSM states: IDLE, WRITE, RETIRE, GAP.
REQ-017 IDLE->WRITE when count>0 and (neither l2pmem_read nor l2pmem_write, or count==DEPTH, or flush pending, or l2pmem_read with l2_address matching any valid entry).
REQ-018 WRITE: pmem_write=1, blocking=1, pmem_address={head line address, OFFSET_BITS zeros}, pmem_wdata=head data, stable until pmem_resp; pmem_resp->RETIRE.
REQ-019 RETIRE: blocking=1, head entry invalidated, head pointer advanced, count decremented at cycle end; unconditional ->GAP.
REQ-020 GAP: all drain outputs 0; unconditional ->IDLE (one idle cycle between writes).
REQ-021 Push and RETIRE in the same cycle SHALL both take effect (count unchanged net).
REQ-022 flush SHALL set flush pending; pending clears, and flush_done pulses one cycle, in the first cycle count==0 with FSM in IDLE; flush with count==0 SHALL pulse flush_done the next cycle.
REQ-023 Outside WRITE, pmem_write=0; pmem_address/pmem_wdata don't-care.

Reset
REQ-024 rst SHALL asynchronously force: FSM IDLE, all valid bits 0, head=tail=0, count=0, flush pending 0.
REQ-025 During reset outputs SHALL be: evict_ready=1, hit=0, pmem_write=0, blocking=0, flush_done=0, count=0.
REQ-026 rst asserted mid-WRITE SHALL abandon the transfer; a later pmem_resp in IDLE SHALL be ignored.

Verification
REQ-027 Push 0x1000/0xAA.., l2pmem idle -> next cycle WRITE, pmem_address=0x1000; pmem_resp after 3 cycles -> RETIRE, GAP, IDLE; count 1->0.
REQ-028 Hold l2pmem_write=1, push 4 lines (DEPTH=4) -> evict_ready=0 at count=4, drain starts despite l2pmem_write; 5th distinct push ignored.
REQ-029 Push 0x2000/A then 0x2000/B while stalled -> count=1, lookup 0x2004 gives hit=1, hit_data=B.
REQ-030 Head 0x3000 in WRITE, push 0x3000/C -> count=2, pmem_wdata unchanged; after retire second write carries C.
REQ-031 l2pmem_read=1 with l2_address matching entry 0x4000 -> drain starts; non-matching address -> remains IDLE.
REQ-032 flush with 3 entries -> three WRITE/RETIRE/GAP sequences, flush_done single pulse when count=0; rst mid-WRITE -> count=0, pmem_write=0 immediately.

Source files
------------

// File: rtl/multi_entry_eviction_buffer.sv
// Eviction (victim) buffer between an L2 cache and physical memory.
// Victim lines are queued in a circular FIFO, coalesced by line address,
// served back to L2 on lookup hits, and drained to pmem one line at a time
// whenever L2 is not using the memory port (or the buffer must make room).
module multi_entry_eviction_buffer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned OFFSET_BITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  // victim push from L2
  input  logic                    evict_valid,
  input  logic [ADDR_WIDTH-1:0]   evict_address,
  input  logic [LINE_WIDTH-1:0]   evict_data,
  output logic                    evict_ready,
  // L2 lookup
  input  logic [ADDR_WIDTH-1:0]   l2_address,
  output logic                    hit,
  output logic [LINE_WIDTH-1:0]   hit_data,
  // L2 memory-port ownership
  input  logic                    l2pmem_read,
  input  logic                    l2pmem_write,
  // drain port to pmem
  output logic                    pmem_write,
  output logic [ADDR_WIDTH-1:0]   pmem_address,
  output logic [LINE_WIDTH-1:0]   pmem_wdata,
  input  logic                    pmem_resp,
  // control / status
  input  logic                    flush,
  output logic                    flush_done,
  output logic                    blocking,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TAG_W = ADDR_WIDTH - OFFSET_BITS;

  typedef enum logic [1:0] {StIdle, StWrite, StRetire, StGap} state_e;

  state_e                state_q, state_d;
  logic [DEPTH-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [DEPTH];
  logic [LINE_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  flush_pend_q, flush_pend_d;

  logic [TAG_W-1:0]      push_tag, look_tag;
  logic [PTR_W-1:0]      look_idx, co_scan_idx, co_idx;
  logic                  co_hit, in_flight, full;
  logic                  alloc, do_coalesce, pop;

  // Offset bits never take part in line compares.
  logic unused_offsets;
  assign unused_offsets = ^{evict_address[OFFSET_BITS-1:0], l2_address[OFFSET_BITS-1:0]};

  assign push_tag    = evict_address[ADDR_WIDTH-1:OFFSET_BITS];
  assign look_tag    = l2_address[ADDR_WIDTH-1:OFFSET_BITS];
  assign full        = (count_q == CNT_W'(DEPTH));
  assign in_flight   = (state_q == StWrite) || (state_q == StRetire);
  assign evict_ready = !full;
  assign count       = count_q;
  assign pop         = (state_q == StRetire);

  // Lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    look_idx = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      look_idx = head_q + PTR_W'(k);
      if (valid_q[look_idx] && (tag_q[look_idx] == look_tag)) begin
        hit      = 1'b1;
        hit_data = data_q[look_idx];
      end
    end
  end

  // Coalesce search: the head is excluded while its data is on the way to pmem.
  always_comb begin
    co_hit      = 1'b0;
    co_idx      = '0;
    co_scan_idx = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      co_scan_idx = head_q + PTR_W'(k);
      if (valid_q[co_scan_idx] && (tag_q[co_scan_idx] == push_tag) &&
          !(in_flight && (co_scan_idx == head_q))) begin
        co_hit = 1'b1;
        co_idx = co_scan_idx;
      end
    end
  end

  // Push decode: coalesce is always accepted, allocation needs a free slot.
  always_comb begin
    do_coalesce = evict_valid && co_hit;
    alloc       = evict_valid && !co_hit && !full;
  end

  // Occupancy bookkeeping for a simultaneous push and retire.
  always_comb begin
    count_d = count_q;
    if (alloc && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!alloc && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Flush pending is held until the buffer is empty and the drain FSM is idle.
  always_comb begin
    flush_done   = flush_pend_q && (state_q == StIdle) && (count_q == '0);
    flush_pend_d = (flush_pend_q && !flush_done) || flush;
  end

  // Valid bits, pointers, count and flush state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      count_q      <= count_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Line payload storage; only qualified by valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[tail_q]  <= push_tag;
      data_q[tail_q] <= evict_data;
    end else if (do_coalesce) begin
      data_q[co_idx] <= evict_data;
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Drain FSM next state: drain when L2 leaves pmem free, or when forced.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if ((count_q != '0) &&
            (!(l2pmem_read || l2pmem_write) || full || flush_pend_q ||
             (l2pmem_read && hit))) begin
          state_d = StWrite;
        end
      end
      StWrite:  if (pmem_resp) state_d = StRetire;
      StRetire: state_d = StGap;
      StGap:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Drain FSM outputs.
  always_comb begin
    pmem_write   = 1'b0;
    blocking     = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state_q)
      StWrite: begin
        pmem_write   = 1'b1;
        blocking     = 1'b1;
        pmem_address = {tag_q[head_q], {OFFSET_BITS{1'b0}}};
        pmem_wdata   = data_q[head_q];
      end
      StRetire: blocking = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_entry_eviction_buffer.sv
module tb_multi_entry_eviction_buffer;

  localparam int DEPTH = 4;
  localparam int LW    = 256;
  localparam int AW    = 32;
  localparam int OB    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          evict_valid;
  logic [AW-1:0] evict_address;
  logic [LW-1:0] evict_data;
  logic          evict_ready;
  logic [AW-1:0] l2_address;
  logic          hit;
  logic [LW-1:0] hit_data;
  logic          l2pmem_read, l2pmem_write;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp;
  logic          flush, flush_done, blocking;
  logic [2:0]    count;

  int n_cmp = 0;
  int n_bad = 0;

  multi_entry_eviction_buffer #(
    .DEPTH(DEPTH), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .OFFSET_BITS(OB)
  ) dut (
    .clk(clk), .rst(rst),
    .evict_valid(evict_valid), .evict_address(evict_address), .evict_data(evict_data),
    .evict_ready(evict_ready),
    .l2_address(l2_address), .hit(hit), .hit_data(hit_data),
    .l2pmem_read(l2pmem_read), .l2pmem_write(l2pmem_write),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp),
    .flush(flush), .flush_done(flush_done), .blocking(blocking), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_inputs();
    evict_valid   = 1'b0;
    evict_address = '0;
    evict_data    = '0;
    l2_address    = '0;
    l2pmem_read   = 1'b0;
    l2pmem_write  = 1'b0;
    pmem_resp     = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic apply_reset();
    set_idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [LW-1:0] d);
    evict_valid   = 1'b1;
    evict_address = a;
    evict_data    = d;
  endtask

  task automatic test_reset();
    apply_reset();
    push(32'h1100, {32{8'h5A}});
    tick();
    evict_valid = 1'b0;
    l2_address  = 32'h1100;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (evict_ready !== 1'b1 || hit !== 1'b0 || pmem_write !== 1'b0 || blocking !== 1'b0 ||
        flush_done !== 1'b0 || count !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b hit=%b pw=%b blk=%b fd=%b cnt=%0d want 1 0 0 0 0 0",
               evict_ready, hit, pmem_write, blocking, flush_done, count);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_drain();
    logic [LW-1:0] d;
    d = {32{8'hAA}};
    apply_reset();
    push(32'h1000, d);
    tick();
    evict_valid = 1'b0;
    #1;
    n_cmp++;
    if (count !== 3'd1 || pmem_write !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_accept: got cnt=%0d pw=%b want 1 0", count, pmem_write);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (pmem_write !== 1'b1 || blocking !== 1'b1 || pmem_address !== 32'h1000 ||
          pmem_wdata !== d) begin
        n_bad++;
        $display("FAIL drain_write[%0d]: got pw=%b blk=%b addr=%h want 1 1 00001000",
                 i, pmem_write, blocking, pmem_address);
      end
    end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    n_cmp++;
    if (pmem_write !== 1'b0 || blocking !== 1'b1 || count !== 3'd1) begin
      n_bad++;
      $display("FAIL drain_retire: got pw=%b blk=%b cnt=%0d want 0 1 1", pmem_write, blocking, count);
    end
    tick();
    n_cmp++;
    if (pmem_write !== 1'b0 || blocking !== 1'b0 || count !== 3'd0) begin
      n_bad++;
      $display("FAIL drain_gap: got pw=%b blk=%b cnt=%0d want 0 0 0", pmem_write, blocking, count);
    end
    tick();
    n_cmp++;
    if (pmem_write !== 1'b0 || blocking !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_idle: got pw=%b blk=%b want 0 0", pmem_write, blocking);
    end
  endtask

  task automatic test_full();
    apply_reset();
    l2pmem_write = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      push(32'h5000 + 32'(i * 32), LW'(i + 1));
      #1;
      n_cmp++;
      if (evict_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL full_ready[%0d]: got %b want 1", i, evict_ready);
      end
      tick();
    end
    evict_valid = 1'b0;
    #1;
    n_cmp++;
    if (count !== 3'd4 || evict_ready !== 1'b0 || pmem_write !== 1'b0) begin
      n_bad++;
      $display("FAIL full_state: got cnt=%0d rdy=%b pw=%b want 4 0 0", count, evict_ready, pmem_write);
    end
    push(32'h6000, {8{32'hDEAD_BEEF}});
    tick();
    evict_valid = 1'b0;
    l2_address  = 32'h6000;
    #1;
    n_cmp++;
    if (count !== 3'd4 || hit !== 1'b0 || pmem_write !== 1'b1 || pmem_address !== 32'h5000 ||
        pmem_wdata !== LW'(1)) begin
      n_bad++;
      $display("FAIL full_drain: got cnt=%0d hit=%b pw=%b addr=%h want 4 0 1 00005000",
               count, hit, pmem_write, pmem_address);
    end
  endtask

  task automatic test_coalesce();
    logic [LW-1:0] a, b;
    a = {32{8'hA1}};
    b = {32{8'hB2}};
    apply_reset();
    l2pmem_write = 1'b1;
    l2_address   = 32'h2000;
    push(32'h2000, a);
    #1;
    n_cmp++;
    if (hit !== 1'b0) begin
      n_bad++;
      $display("FAIL coal_same_cycle: got hit=%b want 0", hit);
    end
    tick();
    push(32'h2000, b);
    tick();
    evict_valid = 1'b0;
    l2_address  = 32'h2004;
    #1;
    n_cmp++;
    if (count !== 3'd1 || hit !== 1'b1 || hit_data !== b || pmem_write !== 1'b0) begin
      n_bad++;
      $display("FAIL coalesce: got cnt=%0d hit=%b data=%h pw=%b want 1 1 %h 0",
               count, hit, hit_data[31:0], pmem_write, b[31:0]);
    end
  endtask

  task automatic test_inflight();
    logic [LW-1:0] c0, c1;
    bit seen;
    c0 = {32{8'hC0}};
    c1 = {32{8'hC1}};
    apply_reset();
    push(32'h3000, c0);
    tick();
    evict_valid = 1'b0;
    tick();
    n_cmp++;
    if (pmem_write !== 1'b1 || pmem_wdata !== c0) begin
      n_bad++;
      $display("FAIL infl_first: got pw=%b data=%h want 1 %h", pmem_write, pmem_wdata[31:0], c0[31:0]);
    end
    push(32'h3000, c1);
    tick();
    evict_valid = 1'b0;
    l2_address  = 32'h3000;
    #1;
    n_cmp++;
    if (count !== 3'd2 || pmem_write !== 1'b1 || pmem_wdata !== c0 || hit_data !== c1) begin
      n_bad++;
      $display("FAIL infl_alloc: got cnt=%0d pw=%b wdata=%h hdata=%h want 2 1 %h %h",
               count, pmem_write, pmem_wdata[31:0], hit_data[31:0], c0[31:0], c1[31:0]);
    end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (pmem_write === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen || pmem_address !== 32'h3000 || pmem_wdata !== c1) begin
      n_bad++;
      $display("FAIL infl_second: got seen=%0d addr=%h data=%h want 1 00003000 %h",
               seen, pmem_address, pmem_wdata[31:0], c1[31:0]);
    end
  endtask

  task automatic test_read_match();
    apply_reset();
    l2pmem_read = 1'b1;
    l2_address  = 32'h5000;
    push(32'h4000, {32{8'hD4}});
    tick();
    evict_valid = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (pmem_write !== 1'b0 || count !== 3'd1) begin
      n_bad++;
      $display("FAIL read_nomatch: got pw=%b cnt=%0d want 0 1", pmem_write, count);
    end
    l2_address = 32'h4010;
    tick();
    n_cmp++;
    if (pmem_write !== 1'b1 || pmem_address !== 32'h4000) begin
      n_bad++;
      $display("FAIL read_match: got pw=%b addr=%h want 1 00004000", pmem_write, pmem_address);
    end
  endtask

  task automatic test_flush_and_reset();
    int nwr, nfd;
    apply_reset();
    l2pmem_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(32'h7000 + 32'(i * 32), LW'(i + 10));
      tick();
    end
    evict_valid = 1'b0;
    flush       = 1'b1;
    tick();
    flush = 1'b0;
    nwr = 0;
    nfd = 0;
    for (int c = 0; c < 30; c++) begin
      if (pmem_write === 1'b1) begin
        n_cmp++;
        if (pmem_address !== 32'h7000 + 32'(nwr * 32) || pmem_wdata !== LW'(nwr + 10)) begin
          n_bad++;
          $display("FAIL flush_write[%0d]: got addr=%h want %h", nwr, pmem_address,
                   32'h7000 + 32'(nwr * 32));
        end
        nwr++;
      end
      if (flush_done === 1'b1) begin
        nfd++;
        n_cmp++;
        if (count !== 3'd0) begin
          n_bad++;
          $display("FAIL flush_done_cnt: got cnt=%0d want 0", count);
        end
      end
      pmem_resp = pmem_write;
      tick();
    end
    pmem_resp = 1'b0;
    n_cmp++;
    if (nwr !== 3 || nfd !== 1) begin
      n_bad++;
      $display("FAIL flush_totals: got writes=%0d pulses=%0d want 3 1", nwr, nfd);
    end
    l2pmem_write = 1'b0;
    flush        = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (flush_done !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_empty: got fd=%b want 1", flush_done);
    end
    tick();
    n_cmp++;
    if (flush_done !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_empty_pulse: got fd=%b want 0", flush_done);
    end
    push(32'h7100, {32{8'hE7}});
    tick();
    evict_valid = 1'b0;
    tick();
    n_cmp++;
    if (pmem_write !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_setup: got pw=%b want 1", pmem_write);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (count !== 3'd0 || pmem_write !== 1'b0 || blocking !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_write: got cnt=%0d pw=%b blk=%b want 0 0 0", count, pmem_write, blocking);
    end
    tick();
    rst       = 1'b0;
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    tick();
    n_cmp++;
    if (count !== 3'd0 || pmem_write !== 1'b0 || blocking !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_late_resp: got cnt=%0d pw=%b blk=%b want 0 0 0", count, pmem_write, blocking);
    end
  endtask

  // Reference: ordered list of buffered lines (front = oldest) plus drain phase
  // 0 idle, 1 writing, 2 retiring, 3 gap.
  typedef struct {
    logic [AW-OB-1:0] tag;
    logic [LW-1:0]    data;
  } ent_t;

  task automatic test_random(input int cycles);
    ent_t          mq[$];
    ent_t          ne;
    int            phase, nphase, co;
    bit            pend, in_fl, e_hit, e_fd, do_new;
    logic [LW-1:0] e_hd;
    int            sz;
    apply_reset();
    phase = 0;
    pend  = 0;
    for (int c = 0; c < cycles; c++) begin
      evict_valid   = ($urandom_range(0, 2) != 0);
      evict_address = 32'h8000 + 32'($urandom_range(0, 5) * 32) + 32'($urandom_range(0, 31));
      evict_data    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      l2_address    = 32'h8000 + 32'($urandom_range(0, 6) * 32) + 32'($urandom_range(0, 31));
      l2pmem_read   = ($urandom_range(0, 3) == 0);
      l2pmem_write  = ($urandom_range(0, 2) == 0);
      pmem_resp     = ($urandom_range(0, 2) == 0);
      flush         = ($urandom_range(0, 19) == 0);
      #1;
      sz    = mq.size();
      e_hit = 0;
      e_hd  = '0;
      foreach (mq[i]) begin
        if (mq[i].tag == l2_address[AW-1:OB]) begin
          e_hit = 1;
          e_hd  = mq[i].data;
        end
      end
      e_fd = pend && phase == 0 && sz == 0;
      n_cmp++;
      if (evict_ready !== (sz < DEPTH) || count !== 3'(sz)) begin
        n_bad++;
        $display("FAIL rnd_occ cyc %0d: got rdy=%b cnt=%0d want %b %0d", c, evict_ready, count,
                 sz < DEPTH, sz);
      end
      n_cmp++;
      if (hit !== e_hit || (e_hit && hit_data !== e_hd)) begin
        n_bad++;
        $display("FAIL rnd_hit cyc %0d: got hit=%b data=%h want %b %h", c, hit, hit_data[31:0],
                 e_hit, e_hd[31:0]);
      end
      n_cmp++;
      if (pmem_write !== (phase == 1) || blocking !== (phase == 1 || phase == 2) ||
          flush_done !== e_fd) begin
        n_bad++;
        $display("FAIL rnd_ctl cyc %0d: got pw=%b blk=%b fd=%b want %b %b %b", c, pmem_write,
                 blocking, flush_done, phase == 1, phase == 1 || phase == 2, e_fd);
      end
      if (phase == 1) begin
        n_cmp++;
        if (pmem_address !== {mq[0].tag, 5'b0} || pmem_wdata !== mq[0].data) begin
          n_bad++;
          $display("FAIL rnd_wr cyc %0d: got addr=%h want %h", c, pmem_address, {mq[0].tag, 5'b0});
        end
      end
      // advance the reference
      in_fl = (phase == 1 || phase == 2);
      co    = -1;
      foreach (mq[i]) begin
        if (mq[i].tag == evict_address[AW-1:OB] && !(i == 0 && in_fl)) co = i;
      end
      nphase = phase;
      case (phase)
        0: if (sz > 0 && (!(l2pmem_read || l2pmem_write) || sz == DEPTH || pend ||
                          (l2pmem_read && e_hit))) nphase = 1;
        1: if (pmem_resp) nphase = 2;
        2: nphase = 3;
        default: nphase = 0;
      endcase
      pend   = (pend && !e_fd) || flush;
      do_new = 0;
      if (evict_valid) begin
        if (co >= 0) mq[co].data = evict_data;
        else if (sz < DEPTH) do_new = 1;
      end
      if (phase == 2) void'(mq.pop_front());
      if (do_new) begin
        ne.tag  = evict_address[AW-1:OB];
        ne.data = evict_data;
        mq.push_back(ne);
      end
      phase = nphase;
      tick();
    end
    set_idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    set_idle_inputs();
    test_reset();
    test_single_drain();
    test_full();
    test_coalesce();
    test_inflight();
    test_read_match();
    test_flush_and_reset();
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
